// File: rtl/frame_formatter.sv
// ---------------------------------------------------------------------------
// frame_formatter
//
// Packs one CCD frame into the USB byte stream. A frame-start pulse snapshots
// the sensor geometry and tuning values, a fixed 32-byte header is emitted,
// and then exactly ACTIVE_X*ACTIVE_Y*2 ADC bytes are passed through
// combinationally to the FIFO. Bytes lost to FIFO back-pressure or strobed
// outside the pixel window are counted.
//
// FSM states:
//   state     | meaning
//   ----------+------------------------------------------------------------
//   ST_IDLE   | waiting for FRAME_START; PIX_W ignored
//   ST_HEADER | writing header bytes 0..31, stalls while FIFO_FULL
//   ST_PIXELS | pass-through of ADC bytes until the expected count is seen
//   ST_DONE   | one cycle; bumps FRAME_CNT
//
// Ports:
//   CLK, RST            system clock, asynchronous active-high reset
//   FRAME_START         one-cycle frame start pulse
//   PIX_W, PIX_DATA     ADC byte strobe and byte (high byte first)
//   PARAM_*             sensor geometry, latched at frame start
//   GAIN, OFFSET,
//   INTEGRATION         tuning values, latched at frame start
//   FIFO_FULL           USB FIFO full flag
//   FIFO_DIN, FIFO_WR   byte and write enable to the FIFO
//   BUSY                high while a frame is in progress
//   OVERFLOW            sticky dropped-byte flag (cleared only by RST)
//   FRAME_CNT           completed frames, wraps
//   DROP_CNT            dropped bytes in the current/last frame, saturates
// ---------------------------------------------------------------------------
module frame_formatter #(
    parameter int HDR_LEN = 32
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        FRAME_START,
    input  logic        PIX_W,
    input  logic [7:0]  PIX_DATA,
    input  logic [15:0] PARAM_X,
    input  logic [15:0] PARAM_Y,
    input  logic [15:0] PARAM_ACTIVE_X,
    input  logic [15:0] PARAM_ACTIVE_Y,
    input  logic [15:0] PARAM_OFFSET_X,
    input  logic [15:0] PARAM_OFFSET_Y,
    input  logic [5:0]  GAIN,
    input  logic [8:0]  OFFSET,
    input  logic [31:0] INTEGRATION,
    input  logic        FIFO_FULL,
    output logic [7:0]  FIFO_DIN,
    output logic        FIFO_WR,
    output logic        BUSY,
    output logic        OVERFLOW,
    output logic [15:0] FRAME_CNT,
    output logic [15:0] DROP_CNT
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEADER,
        ST_PIXELS,
        ST_DONE
    } state_t;

    localparam logic [4:0] HDR_LAST = 5'(HDR_LEN - 1);

    state_t      state;
    state_t      state_nxt;

    logic [15:0] x_q;
    logic [15:0] y_q;
    logic [15:0] active_x_q;
    logic [15:0] active_y_q;
    logic [15:0] offset_x_q;
    logic [15:0] offset_y_q;
    logic [5:0]  gain_q;
    logic [8:0]  offset_q;
    logic [31:0] integration_q;
    logic [15:0] frame_snap_q;
    logic [32:0] bytes_q;

    logic [4:0]  hdr_idx;
    logic [32:0] pix_cnt;
    logic [15:0] frame_cnt;
    logic [15:0] drop_cnt;
    logic        overflow;

    logic [7:0]  hdr_byte;
    logic        pix_take;
    logic        drop;
    logic        start;

    assign start = (state == ST_IDLE) && FRAME_START;

    // Header byte mux; multi-byte fields are little-endian.
    always_comb begin
        hdr_byte = 8'h20;
        case (hdr_idx)
            5'd0:  hdr_byte = 8'h41;
            5'd1:  hdr_byte = 8'h43;
            5'd2:  hdr_byte = 8'h4D;
            5'd3:  hdr_byte = 8'h50;
            5'd4:  hdr_byte = x_q[7:0];
            5'd5:  hdr_byte = x_q[15:8];
            5'd6:  hdr_byte = y_q[7:0];
            5'd7:  hdr_byte = y_q[15:8];
            5'd8:  hdr_byte = active_x_q[7:0];
            5'd9:  hdr_byte = active_x_q[15:8];
            5'd10: hdr_byte = active_y_q[7:0];
            5'd11: hdr_byte = active_y_q[15:8];
            5'd12: hdr_byte = offset_x_q[7:0];
            5'd13: hdr_byte = offset_x_q[15:8];
            5'd14: hdr_byte = offset_y_q[7:0];
            5'd15: hdr_byte = offset_y_q[15:8];
            5'd16: hdr_byte = 8'h00;
            5'd17: hdr_byte = {2'b00, gain_q};
            5'd18: hdr_byte = offset_q[7:0];
            5'd19: hdr_byte = {7'b0, offset_q[8]};
            5'd20: hdr_byte = integration_q[7:0];
            5'd21: hdr_byte = integration_q[15:8];
            5'd22: hdr_byte = integration_q[23:16];
            5'd23: hdr_byte = integration_q[31:24];
            5'd24: hdr_byte = frame_snap_q[7:0];
            5'd25: hdr_byte = frame_snap_q[15:8];
            default: hdr_byte = 8'h20;
        endcase
    end

    always_comb begin
        state_nxt = state;
        FIFO_WR   = 1'b0;
        FIFO_DIN  = hdr_byte;
        pix_take  = 1'b0;
        drop      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (FRAME_START) state_nxt = ST_HEADER;
            end
            ST_HEADER: begin
                FIFO_WR = ~FIFO_FULL;
                drop    = PIX_W;
                if (!FIFO_FULL && hdr_idx == HDR_LAST)
                    state_nxt = (bytes_q == 33'd0) ? ST_DONE : ST_PIXELS;
            end
            ST_PIXELS: begin
                FIFO_WR  = PIX_W & ~FIFO_FULL;
                FIFO_DIN = PIX_DATA;
                pix_take = PIX_W;
                drop     = PIX_W & FIFO_FULL;
                // Dropped strobes still count toward the frame length.
                if (PIX_W && pix_cnt == bytes_q - 33'd1) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                drop      = PIX_W;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state         <= ST_IDLE;
            x_q           <= '0;
            y_q           <= '0;
            active_x_q    <= '0;
            active_y_q    <= '0;
            offset_x_q    <= '0;
            offset_y_q    <= '0;
            gain_q        <= '0;
            offset_q      <= '0;
            integration_q <= '0;
            frame_snap_q  <= '0;
            bytes_q       <= '0;
            hdr_idx       <= '0;
            pix_cnt       <= '0;
            frame_cnt     <= '0;
            drop_cnt      <= '0;
            overflow      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start) begin
                x_q           <= PARAM_X;
                y_q           <= PARAM_Y;
                active_x_q    <= PARAM_ACTIVE_X;
                active_y_q    <= PARAM_ACTIVE_Y;
                offset_x_q    <= PARAM_OFFSET_X;
                offset_y_q    <= PARAM_OFFSET_Y;
                gain_q        <= GAIN;
                offset_q      <= OFFSET;
                integration_q <= INTEGRATION;
                frame_snap_q  <= frame_cnt;
                bytes_q       <= ({17'b0, PARAM_ACTIVE_X} * {17'b0, PARAM_ACTIVE_Y}) << 1;
                hdr_idx       <= '0;
                pix_cnt       <= '0;
                drop_cnt      <= '0;
            end
            if (state == ST_HEADER && FIFO_WR) hdr_idx <= hdr_idx + 5'd1;
            if (pix_take) pix_cnt <= pix_cnt + 33'd1;
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            end
            if (state == ST_DONE) frame_cnt <= frame_cnt + 16'd1;
        end
    end

    assign BUSY      = (state != ST_IDLE);
    assign OVERFLOW  = overflow;
    assign FRAME_CNT = frame_cnt;
    assign DROP_CNT  = drop_cnt;

endmodule

// File: tb/tb_frame_formatter.sv
module tb_frame_formatter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        FRAME_START;
    logic        PIX_W;
    logic [7:0]  PIX_DATA;
    logic [15:0] PARAM_X, PARAM_Y, PARAM_ACTIVE_X, PARAM_ACTIVE_Y;
    logic [15:0] PARAM_OFFSET_X, PARAM_OFFSET_Y;
    logic [5:0]  GAIN;
    logic [8:0]  OFFSET;
    logic [31:0] INTEGRATION;
    logic        FIFO_FULL;
    logic [7:0]  FIFO_DIN;
    logic        FIFO_WR;
    logic        BUSY;
    logic        OVERFLOW;
    logic [15:0] FRAME_CNT;
    logic [15:0] DROP_CNT;

    frame_formatter #(.HDR_LEN(32)) dut (
        .CLK(CLK), .RST(RST), .FRAME_START(FRAME_START),
        .PIX_W(PIX_W), .PIX_DATA(PIX_DATA),
        .PARAM_X(PARAM_X), .PARAM_Y(PARAM_Y),
        .PARAM_ACTIVE_X(PARAM_ACTIVE_X), .PARAM_ACTIVE_Y(PARAM_ACTIVE_Y),
        .PARAM_OFFSET_X(PARAM_OFFSET_X), .PARAM_OFFSET_Y(PARAM_OFFSET_Y),
        .GAIN(GAIN), .OFFSET(OFFSET), .INTEGRATION(INTEGRATION),
        .FIFO_FULL(FIFO_FULL), .FIFO_DIN(FIFO_DIN), .FIFO_WR(FIFO_WR),
        .BUSY(BUSY), .OVERFLOW(OVERFLOW),
        .FRAME_CNT(FRAME_CNT), .DROP_CNT(DROP_CNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int ax;
        int ay;
        int stall_lo;     // header cycles [stall_lo..stall_hi] see FIFO_FULL
        int stall_hi;
        int n_full;       // first n_full pixel strobes see FIFO_FULL
        int n_early;      // PIX_W on the first n_early header cycles
        int fs_pix;       // FRAME_START held during the pixel phase
        int exp_writes;
        int exp_drop;
        int exp_busy;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  act_q[$];
    logic [7:0]  exp_q[$];
    int          busy_cycles = 0;
    logic [15:0] m_fcnt;
    logic        m_ovf;
    int          m_busy;
    int          wr_base;
    int          busy_base;

    // FIFO model: a write sampled on the falling edge is committed on the next rising edge.
    always @(negedge CLK) begin
        if (FIFO_WR === 1'b1) act_q.push_back(FIFO_DIN);
        if (BUSY === 1'b1) busy_cycles++;
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives one frame and predicts the FIFO byte stream from the frame rules:
    // 32 header writes on non-full cycles, then BYTES strobes, then one closing cycle.
    task automatic run_frame(input vec_t v, input bit rnd);
        logic [7:0] hdr[32];
        int hdr_sent, pix_left, drops, hc, strobe, bad, n;
        logic full, pw;
        logic [7:0] d;
        bit finished;

        PARAM_X        = 16'($urandom);
        PARAM_Y        = 16'($urandom);
        PARAM_ACTIVE_X = 16'(v.ax);
        PARAM_ACTIVE_Y = 16'(v.ay);
        PARAM_OFFSET_X = 16'($urandom);
        PARAM_OFFSET_Y = 16'($urandom);
        GAIN           = 6'($urandom);
        OFFSET         = 9'($urandom);
        INTEGRATION    = $urandom;

        hdr[0] = 8'h41; hdr[1] = 8'h43; hdr[2] = 8'h4D; hdr[3] = 8'h50;
        {hdr[5], hdr[4]}   = PARAM_X;
        {hdr[7], hdr[6]}   = PARAM_Y;
        {hdr[9], hdr[8]}   = PARAM_ACTIVE_X;
        {hdr[11], hdr[10]} = PARAM_ACTIVE_Y;
        {hdr[13], hdr[12]} = PARAM_OFFSET_X;
        {hdr[15], hdr[14]} = PARAM_OFFSET_Y;
        hdr[16] = 8'h00;
        hdr[17] = {2'b00, GAIN};
        {hdr[19], hdr[18]} = {7'b0, OFFSET};
        {hdr[23], hdr[22], hdr[21], hdr[20]} = INTEGRATION;
        {hdr[25], hdr[24]} = m_fcnt;
        for (int i = 26; i < 32; i++) hdr[i] = 8'h20;

        exp_q.delete();
        wr_base   = act_q.size();
        busy_base = busy_cycles;
        drops = 0; hdr_sent = 0; hc = 0; strobe = 0; m_busy = 0; finished = 0;
        pix_left = v.ax * v.ay * 2;

        @(posedge CLK); #1;
        FRAME_START = 1'b1;
        PIX_W       = rnd ? 1'($urandom_range(0, 1)) : 1'b0;   // ignored while idle
        FIFO_FULL   = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        PIX_DATA    = 8'($urandom);

        while (!finished) begin
            @(posedge CLK); #1;
            m_busy++;
            d = 8'($urandom);
            if (hdr_sent < 32) begin
                FRAME_START = rnd ? ($urandom_range(0, 15) == 0) : 1'b0;
                full = rnd ? ($urandom_range(0, 3) == 0) : (hc >= v.stall_lo && hc <= v.stall_hi);
                pw   = rnd ? ($urandom_range(0, 9) == 0) : (hc < v.n_early);
                if (!full) begin
                    exp_q.push_back(hdr[hdr_sent]);
                    hdr_sent++;
                end
                if (pw) drops++;
                hc++;
            end else if (pix_left > 0) begin
                FRAME_START = rnd ? ($urandom_range(0, 15) == 0) : (v.fs_pix != 0);
                pw   = rnd ? ($urandom_range(0, 9) < 6) : 1'b1;
                full = rnd ? ($urandom_range(0, 3) == 0) : (strobe < v.n_full);
                if (!rnd) d = 8'(strobe);
                if (pw) begin
                    pix_left--;
                    strobe++;
                    if (full) drops++;
                    else exp_q.push_back(d);
                end
            end else begin
                FRAME_START = rnd ? ($urandom_range(0, 15) == 0) : 1'b0;
                pw   = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
                full = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
                if (pw) drops++;
                m_fcnt++;
                finished = 1;
            end
            FIFO_FULL = full;
            PIX_W     = pw;
            PIX_DATA  = d;
        end

        @(posedge CLK); #1;
        FRAME_START = 1'b0; PIX_W = 1'b0; FIFO_FULL = 1'b0;
        @(negedge CLK); #1;
        if (drops > 0) m_ovf = 1'b1;

        n = act_q.size() - wr_base;
        check("busy_after_frame", BUSY, 0);
        check("write_count", n, exp_q.size());
        bad = 0;
        for (int i = 0; i < n && i < exp_q.size(); i++)
            if (act_q[wr_base + i] !== exp_q[i]) bad++;
        check("stream_bytes_bad", bad, 0);
        check("busy_cycles", busy_cycles - busy_base, m_busy);
        check("frame_cnt", FRAME_CNT, m_fcnt);
        check("drop_cnt", DROP_CNT, (drops > 65535) ? 65535 : drops);
        check("overflow", OVERFLOW, m_ovf);
    endtask

    vec_t tbl[7];
    vec_t r;
    vec_t nom;

    initial begin
        tbl[0] = '{4, 2, -1, -2, 0, 0, 0, 48, 0, 49};   // nominal
        tbl[1] = '{4, 2,  5,  9, 0, 0, 0, 48, 0, 54};   // header back-pressure
        tbl[2] = '{4, 2, -1, -2, 3, 0, 0, 45, 3, 49};   // pixel drops
        tbl[3] = '{3, 1, -1, -2, 0, 2, 0, 38, 2, 39};   // strobes during header
        tbl[4] = '{0, 7, -1, -2, 0, 0, 0, 32, 0, 33};   // zero-size frame
        tbl[5] = '{1, 1, -1, -2, 0, 0, 0, 34, 0, 35};   // single pixel pair
        tbl[6] = '{2, 2, -1, -2, 0, 0, 1, 40, 0, 41};   // FRAME_START during pixels
        nom = tbl[0];

        RST = 1'b1; FRAME_START = 1'b0; PIX_W = 1'b0; PIX_DATA = '0; FIFO_FULL = 1'b0;
        PARAM_X = '0; PARAM_Y = '0; PARAM_ACTIVE_X = '0; PARAM_ACTIVE_Y = '0;
        PARAM_OFFSET_X = '0; PARAM_OFFSET_Y = '0; GAIN = '0; OFFSET = '0; INTEGRATION = '0;
        m_fcnt = '0; m_ovf = 1'b0;
        #1;
        check("rst_fifo_wr", FIFO_WR, 0);
        check("rst_fifo_din", FIFO_DIN, 8'h41);
        check("rst_busy", BUSY, 0);
        check("rst_overflow", OVERFLOW, 0);
        check("rst_frame_cnt", FRAME_CNT, 0);
        check("rst_drop_cnt", DROP_CNT, 0);
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_frame(tbl[i], 1'b0);
            check($sformatf("vec%0d_writes", i), act_q.size() - wr_base, tbl[i].exp_writes);
            check($sformatf("vec%0d_drop", i), DROP_CNT, tbl[i].exp_drop);
            check($sformatf("vec%0d_busy", i), busy_cycles - busy_base, tbl[i].exp_busy);
            if (i == 0) begin
                check("vec0_magic",
                      {act_q[wr_base], act_q[wr_base + 1], act_q[wr_base + 2], act_q[wr_base + 3]},
                      32'h41434D50);
                check("vec0_frame_cnt", FRAME_CNT, 1);
                check("vec0_overflow", OVERFLOW, 0);
            end
        end

        for (int k = 0; k < 20; k++) begin
            r = '{0, 0, -1, -2, 0, 0, 0, 0, 0, 0};
            r.ax = $urandom_range(0, 6);
            r.ay = $urandom_range(0, 4);
            run_frame(r, 1'b1);
        end

        // Reset in the middle of the pixel phase.
        @(posedge CLK); #1;
        PARAM_ACTIVE_X = 16'd8; PARAM_ACTIVE_Y = 16'd4; FRAME_START = 1'b1;
        @(posedge CLK); #1;
        FRAME_START = 1'b0;
        repeat (32) @(posedge CLK);
        #1 PIX_W = 1'b1; PIX_DATA = 8'h5A;
        repeat (5) @(posedge CLK);
        #1;
        check("mid_busy", BUSY, 1);
        check("mid_fifo_wr", FIFO_WR, 1);
        RST = 1'b1; PIX_W = 1'b0;
        #1;
        check("midrst_fifo_wr", FIFO_WR, 0);
        check("midrst_fifo_din", FIFO_DIN, 8'h41);
        check("midrst_busy", BUSY, 0);
        check("midrst_overflow", OVERFLOW, 0);
        check("midrst_frame_cnt", FRAME_CNT, 0);
        check("midrst_drop_cnt", DROP_CNT, 0);
        @(posedge CLK); #1 RST = 1'b0;
        m_fcnt = '0; m_ovf = 1'b0;

        run_frame(nom, 1'b0);
        check("post_rst_hdr_fcnt", {act_q[wr_base + 25], act_q[wr_base + 24]}, 16'h0000);
        check("post_rst_frame_cnt", FRAME_CNT, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_formatter.md
# frame_formatter

Packs one CCD frame into the USB byte stream. It sits between the CCD timing generator / AD9826 capture path and the USB FIFO. On each frame-start pulse it snapshots the sensor geometry and tuning registers, then emits a fixed 32-byte header. It then passes exactly the expected number of pixel bytes from the ADC, and counts any bytes lost to FIFO back-pressure or out-of-window strobes.

## Interface
Parameters:
- HDR_LEN, 32: header length in bytes; fixed at 32 for this format.

Ports:
- CLK  in  1  system clock (48 MHz domain). Single clock.
- RST  in  1  asynchronous, active-high reset.
- FRAME_START  in  1  one-cycle pulse from the timing generator; starts a frame.
- PIX_W  in  1  ADC byte strobe, one byte per asserted cycle.
- PIX_DATA  in  8  ADC byte; the AD9826 high byte comes first, then the low byte.
- PARAM_X, PARAM_Y, PARAM_ACTIVE_X, PARAM_ACTIVE_Y, PARAM_OFFSET_X, PARAM_OFFSET_Y  in  16 each  sensor geometry.
- GAIN  in  6; OFFSET  in  9; INTEGRATION  in  32  tuning values, copied into the header.
- FIFO_FULL  in  1  USB FIFO full flag.
- FIFO_DIN  out  8  byte to the FIFO.
- FIFO_WR  out  1  FIFO write enable; the FIFO samples a write on each CLK edge where this is 1.
- BUSY  out  1  high while not IDLE.
- OVERFLOW  out  1  sticky; set on any dropped byte.
- FRAME_CNT  out  16  number of completed frames; wraps.
- DROP_CNT  out  16  dropped bytes in the current or last frame; saturates at 16'hFFFF.

## Operation
State machine:
- IDLE: on FRAME_START, do the following at the same edge, then go to HEADER:
  - latch all PARAM_*, GAIN, OFFSET and INTEGRATION;
  - latch BYTES = ACTIVE_X*ACTIVE_Y*2 as a 33-bit product;
  - clear hdr_idx, pix_cnt and DROP_CNT.
- HEADER, outputs:
  - FIFO_WR = ~FIFO_FULL (combinational).
  - FIFO_DIN = header byte at hdr_idx.
  - hdr_idx increments on every edge where FIFO_WR=1.
  - If FIFO_FULL=1, the block stalls with no loss.
- HEADER, transitions:
  - After the write of byte 31, go to PIXELS.
  - If BYTES=0, go directly to DONE instead.
- PIXELS:
  - FIFO_WR = PIX_W & ~FIFO_FULL; FIFO_DIN = PIX_DATA. Zero latency, combinational.
  - pix_cnt increments on every PIX_W, including dropped bytes.
  - When PIX_W arrives with pix_cnt = BYTES-1, go to DONE.
- DONE: increment FRAME_CNT, then go to IDLE. Lasts one cycle.
- Outside PIXELS (IDLE, HEADER, DONE), FIFO_DIN = header byte and FIFO_WR follows the state rules above.

Header layout, little-endian (multi-byte fields are written low byte first):
- 0-3: "ACMP" (8'h41, 8'h43, 8'h4D, 8'h50).
- 4-15: X, Y, ACTIVE_X, ACTIVE_Y, OFFSET_X, OFFSET_Y.
- 16: 8'h00.
- 17: {2'b00, GAIN}.
- 18-19: {7'b0, OFFSET}.
- 20-23: INTEGRATION.
- 24-25: FRAME_CNT value at FRAME_START.
- 26-31: 8'h20.

Drop and ignore rules:
- PIX_W in PIXELS with FIFO_FULL=1: byte dropped; DROP_CNT+1; OVERFLOW set.
- PIX_W in HEADER or DONE: byte dropped; DROP_CNT+1; OVERFLOW set; pix_cnt unchanged.
- PIX_W in IDLE: ignored and not counted.
- FRAME_START while BUSY: ignored; no restart, no counter change.
- OVERFLOW is cleared only by RST.

## Timing
- Reset values:
  - Outputs: FIFO_WR=0, FIFO_DIN=8'h41 (byte 0 of the IDLE mux), BUSY=0, OVERFLOW=0, FRAME_CNT=0, DROP_CNT=0.
  - Internal: state IDLE, hdr_idx=0, pix_cnt=0.
- FRAME_START sampled at edge k:
  - BUSY=1 and FIFO_WR=1 (byte 0) in the cycle after edge k, if FIFO_FULL=0.
  - With no back-pressure, the header occupies 32 consecutive cycles.
- Pixel path: combinational pass-through, zero cycles latency.
- The last pixel write and the transition to DONE happen at the same edge.
- BUSY falls 2 cycles after the last PIX_W (DONE, then IDLE).
- RST mid-frame: immediate return to IDLE; counters cleared; no partial-frame completion.
- FRAME_CNT wraps from 16'hFFFF to 0.

## Test plan
- Nominal frame:
  - Stimulus: ACTIVE_X=4, ACTIVE_Y=2, FIFO never full, FRAME_START, then 16 PIX_W with data 0..15.
  - Required: exactly 48 writes (32 header + 16 pixel), header bytes 0-3 = 41 43 4D 50, FRAME_CNT=1, OVERFLOW=0.
- Header back-pressure:
  - Stimulus: FIFO_FULL=1 for cycles 5-9 of the header.
  - Required: no header byte skipped or duplicated; header ends 5 cycles later.
- Pixel drop:
  - Stimulus: FIFO_FULL=1 during 3 of the 16 PIX_W.
  - Required: 13 pixel writes, DROP_CNT=3, OVERFLOW=1, frame still completes after 16 strobes.
- Early strobes and zero-size frame:
  - Stimulus A: PIX_W during HEADER.
  - Required A: byte dropped and counted; pix_cnt unchanged.
  - Stimulus B: frame with ACTIVE_X=0.
  - Required B: 32 writes only, FRAME_CNT incremented.
- Ignored start and reset:
  - Stimulus A: second FRAME_START during PIXELS.
  - Required A: ignored.
  - Stimulus B: RST asserted mid-PIXELS.
  - Required B: all outputs at reset values immediately; a new frame then starts cleanly with header FRAME_CNT bytes 24-25 = 00 00.
